// File: rtl/pattern_tx_pkg.sv
// Shared state codes for the serial pattern transmitter.
// The state code is also shown directly on the board LEDs.
package pattern_tx_pkg;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE = 2'b00;
    localparam state_t S_SEND = 2'b01;
    localparam state_t S_DONE = 2'b11;

endpackage

// File: rtl/bit_timer.sv
// Mod-DIV bit timer: bit_tick marks the last clock of each held bit.
// With DIV = 1 every enabled clock is a bit boundary, so no counter is built.
module bit_timer #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic bit_tick
);

    generate
        if (DIV == 1) begin : g_pass
            logic unused_inputs;
            assign unused_inputs = clk ^ reset ^ clear;
            assign bit_tick      = en;
        end else begin : g_count
            localparam int CW = $clog2(DIV);

            logic [CW-1:0] count;

            // Count 0..DIV-1 while enabled; clear restarts the bit on a new frame load
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    count <= '0;
                end else if (clear) begin
                    count <= '0;
                end else if (en) begin
                    if (count == CW'(DIV - 1)) begin
                        count <= '0;
                    end else begin
                        count <= count + CW'(1);
                    end
                end
            end

            assign bit_tick = en && (count == CW'(DIV - 1));
        end
    endgenerate

endmodule

// File: rtl/serial_pattern_tx.sv
// Serial stimulus transmitter for the two-in-a-row detector.
// Shifts a WIDTH-bit word out MSB-first, DIV clocks per bit, and drives
// z_exp, the golden "last two frame bits equal" flag, aligned with w.
module serial_pattern_tx
    import pattern_tx_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIV   = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [WIDTH-1:0]         data,
    output logic                     w,
    output logic                     w_valid,
    output logic                     busy,
    output logic                     done,
    output logic                     z_exp,
    output logic [$clog2(WIDTH)-1:0] bit_index,
    output logic [1:0]               state_leds
);

    localparam int IW = $clog2(WIDTH);
    localparam int FW = $clog2(WIDTH + 1);

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] shreg;
    logic             prev_bit;
    logic [FW-1:0]    frame_cnt;
    logic             load;
    logic             sending;
    logic             bit_tick;

    // A start only counts between frames; once SEND begins it is ignored
    assign load    = start && ((state == S_IDLE) || (state == S_DONE));
    assign sending = (state == S_SEND);

    bit_timer #(
        .DIV(DIV)
    ) u_bit_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (load),
        .en      (sending),
        .bit_tick(bit_tick)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; the unused code 2'b10 falls back to IDLE
    always_comb begin
        next_state = S_IDLE;
        case (state)
            S_IDLE:  next_state = start ? S_SEND : S_IDLE;
            S_SEND:  next_state = (bit_tick && (bit_index == '0)) ? S_DONE : S_SEND;
            S_DONE:  next_state = start ? S_SEND : S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Frame datapath: load on accepted start, shift and remember the outgoing bit on each bit boundary
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg     <= '0;
            bit_index <= '0;
            prev_bit  <= 1'b0;
            frame_cnt <= '0;
        end else if (load) begin
            shreg     <= data;
            bit_index <= IW'(WIDTH - 1);
            prev_bit  <= 1'b0;
            frame_cnt <= '0;
        end else if (sending && bit_tick && (bit_index != '0)) begin
            shreg     <= {shreg[WIDTH-2:0], 1'b0};
            bit_index <= bit_index - IW'(1);
            prev_bit  <= shreg[WIDTH-1];
            frame_cnt <= frame_cnt + FW'(1);
        end
    end

    // Outputs decoded from registered state only, never from start
    always_comb begin
        w          = 1'b0;
        w_valid    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        z_exp      = 1'b0;
        state_leds = state;
        case (state)
            S_SEND: begin
                w       = shreg[WIDTH-1];
                w_valid = 1'b1;
                busy    = 1'b1;
                z_exp   = (frame_cnt != '0) && (shreg[WIDTH-1] == prev_bit);
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                w = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Bench for serial_pattern_tx: one DIV = 1 instance and one DIV = 4 instance,
// each frame compared cycle by cycle against a reference computed from the data word.
module tb_serial_pattern_tx;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic       start1 = 1'b0;
    logic       start4 = 1'b0;
    logic [7:0] data1  = 8'h00;
    logic [7:0] data4  = 8'h00;

    logic       w1, wv1, busy1, done1, z1;
    logic [2:0] idx1;
    logic [1:0] leds1;
    logic       w4, wv4, busy4, done4, z4;
    logic [2:0] idx4;
    logic [1:0] leds4;

    int checks   = 0;
    int failures = 0;

    // 10 ns clock; inputs change and outputs are sampled on the falling edge
    always #5 clk = ~clk;

    serial_pattern_tx #(.WIDTH(8), .DIV(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .data(data1),
        .w(w1), .w_valid(wv1), .busy(busy1), .done(done1), .z_exp(z1),
        .bit_index(idx1), .state_leds(leds1)
    );

    serial_pattern_tx #(.WIDTH(8), .DIV(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .data(data4),
        .w(w4), .w_valid(wv4), .busy(busy4), .done(done4), .z_exp(z4),
        .bit_index(idx4), .state_leds(leds4)
    );

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic checkCycle(input int sel, input string tag,
                              input logic ew, input logic ev, input logic eb,
                              input logic ed, input logic ez,
                              input logic [2:0] ei, input logic [1:0] el);
        if (sel == 1) begin
            checkOutput({tag, ".w"},       {7'd0, w4},    {7'd0, ew});
            checkOutput({tag, ".w_valid"}, {7'd0, wv4},   {7'd0, ev});
            checkOutput({tag, ".busy"},    {7'd0, busy4}, {7'd0, eb});
            checkOutput({tag, ".done"},    {7'd0, done4}, {7'd0, ed});
            checkOutput({tag, ".z_exp"},   {7'd0, z4},    {7'd0, ez});
            checkOutput({tag, ".index"},   {5'd0, idx4},  {5'd0, ei});
            checkOutput({tag, ".leds"},    {6'd0, leds4}, {6'd0, el});
        end else begin
            checkOutput({tag, ".w"},       {7'd0, w1},    {7'd0, ew});
            checkOutput({tag, ".w_valid"}, {7'd0, wv1},   {7'd0, ev});
            checkOutput({tag, ".busy"},    {7'd0, busy1}, {7'd0, eb});
            checkOutput({tag, ".done"},    {7'd0, done1}, {7'd0, ed});
            checkOutput({tag, ".z_exp"},   {7'd0, z1},    {7'd0, ez});
            checkOutput({tag, ".index"},   {5'd0, idx1},  {5'd0, ei});
            checkOutput({tag, ".leds"},    {6'd0, leds1}, {6'd0, el});
        end
    endtask

    task automatic checkIdle(input int sel, input string tag);
        checkCycle(sel, tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'b00);
    endtask

    task automatic setStart(input int sel, input logic v, input logic [7:0] d);
        if (sel == 1) begin
            start4 = v;
            data4  = d;
        end else begin
            start1 = v;
            data1  = d;
        end
    endtask

    // Raise start for one sampling edge (or keep it high); returns in the first bit cycle
    task automatic applyStimulus(input int sel, input logic [7:0] d, input bit hold);
        setStart(sel, 1'b1, d);
        @(negedge clk);
        if (!hold) setStart(sel, 1'b0, d);
    endtask

    // Walks one frame from its first bit cycle to its done cycle.
    // mode 0: start low; mode 1: random start/data pokes that must be ignored;
    // mode 2: start held high with nextD presented for the following frame.
    task automatic checkFrame(input int sel, input logic [7:0] d, input int mode, input logic [7:0] nextD);
        int   div;
        int   k;
        logic ez;
        div = (sel == 1) ? 4 : 1;
        for (int c = 0; c < 8 * div; c++) begin
            k  = c / div;
            ez = 1'b0;
            if (k > 0) ez = (d[7-k] == d[8-k]);
            checkCycle(sel, "bit", d[7-k], 1'b1, 1'b1, 1'b0, ez, 3'(7 - k), 2'b01);
            if (mode == 1) setStart(sel, 1'($urandom_range(0, 1)), 8'($urandom));
            else if (mode == 2) setStart(sel, 1'b1, nextD);
            @(negedge clk);
        end
        checkCycle(sel, "done", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 2'b11);
    endtask

    // Test sequence
    initial begin
        int         sel;
        logic [7:0] d;

        repeat (3) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 20; i++) begin
            checkIdle(0, "idle1");
            checkIdle(1, "idle4");
            @(negedge clk);
        end

        applyStimulus(0, 8'b1100_0111, 1'b0);
        checkFrame(0, 8'b1100_0111, 0, 8'h00);
        @(negedge clk);
        checkIdle(0, "after_c7");

        applyStimulus(1, 8'hA5, 1'b0);
        checkFrame(1, 8'hA5, 0, 8'h00);
        @(negedge clk);
        checkIdle(1, "after_a5");

        applyStimulus(0, 8'hFF, 1'b1);
        checkFrame(0, 8'hFF, 2, 8'h00);
        @(negedge clk);
        checkFrame(0, 8'h00, 2, 8'h00);
        setStart(0, 1'b0, 8'h00);
        @(negedge clk);
        checkIdle(0, "after_b2b");

        for (int i = 0; i < 8; i++) begin
            sel = int'($urandom_range(0, 1));
            d   = 8'($urandom);
            applyStimulus(sel, d, 1'b0);
            checkFrame(sel, d, 1, 8'h00);
            setStart(sel, 1'b0, d);
            @(negedge clk);
            checkIdle(sel, "after_rand");
        end

        d = 8'($urandom);
        applyStimulus(0, d, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("pre_reset.busy", {7'd0, busy1}, 8'd1);
        #2 reset = 1'b1;
        #1;
        checkIdle(0, "async_reset");
        checkIdle(1, "async_reset4");
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            checkIdle(0, "post_reset");
            @(negedge clk);
        end

        force dut1.state = 2'b10;
        #1 release dut1.state;
        checkOutput("code10.leds", {6'd0, leds1}, 8'd2);
        checkOutput("code10.w_valid", {7'd0, wv1}, 8'd0);
        @(negedge clk);
        checkIdle(0, "code10_recover");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
